stream_lock_ctrl: RTL and testbench
===================================

Name: stream_lock_ctrl

Overview:
- Sequencer between the DVP capture side and the HDMI transmitter, clocked in the DVP pixel clock domain.
- Holds the TMDS path in reset until three conditions hold: the sensor configuration is done, the TMDS PLL is locked, and STABLE_FRAMES consecutive frames match the expected geometry.
- Releases the TMDS path aligned to a vsync rising edge.
- Drops lock on any geometry error, frame timeout, or loss of PLL/config, counts lock losses, and re-acquires automatically.

Parameters:
- H_DE_CYCLES, 1280: required clk cycles of DE high per line.
- V_LINES, 720: required DE pulses (lines) per frame.
- STABLE_FRAMES, 4: consecutive good frames needed to lock; range 1..15.
- FRAME_TIMEOUT, 2_000_000: clk cycles without a vsync rise before the frame is declared bad.

Ports:
- clk  in  1  DVP pixel clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_done  in  1  sensor configuration complete (level)
- pll_lock  in  1  TMDS PLL lock (level)
- vsync  in  1  DVP vsync
- de  in  1  DVP data enable
- tmds_rst_n  out  1  active-low reset to the HDMI transmitter
- locked  out  1  high in LOCKED
- state  out  2  0=WAIT_CFG, 1=SEARCH, 2=TRACK, 3=LOCKED
- meas_de_len  out  12  DE length of the last line of the last completed frame
- meas_lines  out  11  line count of the last completed frame
- lock_loss_cnt  out  8  LOCKED exits, saturating at 255

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rst_n is sampled on posedge clk; reset is synchronous and active-low.
  - Reset values:
    - state=WAIT_CFG
    - tmds_rst_n=0, locked=0
    - meas_de_len=0, meas_lines=0, lock_loss_cnt=0
    - all internal counters and pipeline registers 0
- Input pipeline
  - vsync and de are each registered twice: vs_q/vs_qq and de_q/de_qq.
  - vs_rise = vs_q & ~vs_qq.
  - de_fall = ~de_q & de_qq.
  - All actions are registered on the edge after the event is visible. The state changes on the 2nd clk edge at which the input is sampled high (vsync) or low (de).
- Frame measurement (active in SEARCH, TRACK, LOCKED)
  - run_cnt (12b) increments while de_q=1 and saturates at 4095.
  - On de_fall:
    - last_len <= run_cnt.
    - line_cnt (11b) increments, saturating at 2047.
    - If run_cnt != H_DE_CYCLES, set frame_bad.
    - run_cnt is cleared.
  - If vs_rise and de_fall occur in the same cycle, that line belongs to the ending frame.
  - If de_q=1 at vs_rise, the ending frame is bad.
  - On vs_rise, good = !frame_bad && line_cnt(incl. same-cycle line)==V_LINES && no DE in progress.
  - On vs_rise, meas_lines and meas_de_len are updated, then frame_bad, line_cnt and timeout_cnt are cleared.
  - timeout_cnt counts cycles since the last vs_rise.
    - Reaching FRAME_TIMEOUT in TRACK or LOCKED acts as a vs_rise with good=0.
    - meas_* are not updated on a timeout.
    - timeout_cnt restarts at 0.
- State machine
  - WAIT_CFG: go to SEARCH when cfg_done && pll_lock.
  - SEARCH: on the first vs_rise, discard the partial frame and go to TRACK with good_cnt=0.
  - TRACK:
    - Good frame: good_cnt++. When good_cnt reaches STABLE_FRAMES, go to LOCKED.
    - Bad frame: good_cnt=0 and stay in TRACK.
  - LOCKED:
    - tmds_rst_n=1 and locked=1, both registered.
    - Both rise on the same edge as state becomes LOCKED, i.e. one cycle after the vs_rise cycle.
    - A bad frame or timeout sends the block to SEARCH. On that edge: tmds_rst_n=0, locked=0, lock_loss_cnt+1 (saturating).
- Priority when events coincide
  - In any state other than WAIT_CFG, a low cfg_done or pll_lock takes priority over everything else.
  - The block goes to WAIT_CFG on the next edge and clears good_cnt, frame_bad, line_cnt, run_cnt and timeout_cnt.
  - lock_loss_cnt increments only if the exit is from LOCKED.
- Outputs
  - tmds_rst_n and locked are 0 in every state except LOCKED.
  - No combinational path from any input to any output.

Test Plan:
1. Reset with parameters H=16, V=4, STABLE=3, TIMEOUT=500 → all outputs 0 and state=0; they stay so while cfg_done=1, pll_lock=0.
2. Raise cfg_done and pll_lock, then drive 5 frames of 4 lines × 16 DE cycles with gaps → state goes 1→2 at the first vsync. locked=1 and tmds_rst_n=1 one cycle after the 4th vsync rise (3 good frames). meas_lines=4, meas_de_len=16.
3. While LOCKED, send a frame with one line of 15 DE cycles → at the next vsync rise +1 cycle: state=1, tmds_rst_n=0, lock_loss_cnt=1, meas_de_len of that frame per the last line.
4. While LOCKED, send a frame with 5 lines → state returns to SEARCH and meas_lines=5. Separately, hold vsync low for 500 cycles in LOCKED → timeout drops lock and lock_loss_cnt increments.
5. In TRACK with good_cnt=2, drop pll_lock for one cycle → state=0 next edge and good_cnt cleared. Re-lock requires SEARCH plus 3 fresh good frames.
6. Force 260 lock losses → lock_loss_cnt holds at 255. Also assert rst_n=0 mid-LOCKED → all outputs return to reset values on that edge.

Source files
------------

// File: rtl/stream_lock_ctrl_if.sv
// Handshake and status bundle between the DVP capture side, the lock sequencer and the HDMI transmitter.
// The master drives the sensor/PLL status and the DVP timing; the slave (sequencer) returns lock status and measurements.
interface stream_lock_ctrl_if;
  logic        cfg_done;
  logic        pll_lock;
  logic        vsync;
  logic        de;
  logic        tmds_rst_n;
  logic        locked;
  logic [1:0]  state;
  logic [11:0] meas_de_len;
  logic [10:0] meas_lines;
  logic [7:0]  lock_loss_cnt;

  modport master (
    output cfg_done, pll_lock, vsync, de,
    input  tmds_rst_n, locked, state, meas_de_len, meas_lines, lock_loss_cnt
  );

  modport slave (
    input  cfg_done, pll_lock, vsync, de,
    output tmds_rst_n, locked, state, meas_de_len, meas_lines, lock_loss_cnt
  );
endinterface

// File: rtl/stream_lock_ctrl.sv
// Holds the TMDS path in reset until config, PLL and frame geometry are stable; releases on a vsync edge.
// Latency: actions land one edge after the double-registered event is visible; no backpressure, all outputs registered.
module stream_lock_ctrl #(
  parameter int H_DE_CYCLES   = 1280,
  parameter int V_LINES       = 720,
  parameter int STABLE_FRAMES = 4,
  parameter int FRAME_TIMEOUT = 2_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_lock_ctrl_if.slave  bus
);

  localparam int                TMO_W   = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [11:0]       H_LEN   = 12'(H_DE_CYCLES);
  localparam logic [10:0]       V_CNT   = 11'(V_LINES);
  localparam logic [3:0]        STABLE  = 4'(STABLE_FRAMES);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(FRAME_TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SEARCH   = 2'd1,
    TRACK    = 2'd2,
    LOCKED   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               vs_q, vs_qq, de_q, de_qq;
  logic [11:0]        run_cnt_q, run_cnt_d;
  logic [11:0]        last_len_q, last_len_d;
  logic [10:0]        line_cnt_q, line_cnt_d;
  logic               frame_bad_q, frame_bad_d;
  logic [TMO_W-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic [3:0]         good_cnt_q, good_cnt_d;
  logic               tmds_rst_n_q, tmds_rst_n_d;
  logic               locked_q, locked_d;
  logic [11:0]        meas_de_len_q, meas_de_len_d;
  logic [10:0]        meas_lines_q, meas_lines_d;
  logic [7:0]         lock_loss_cnt_q, lock_loss_cnt_d;

  logic               vs_rise, de_fall, cfg_ok;
  logic               line_len_bad, frame_good, frame_ok, tmo_hit, frame_end;
  logic [10:0]        lines_total;
  logic [3:0]         good_inc;

  assign vs_rise = vs_q & ~vs_qq;
  assign de_fall = ~de_q & de_qq;
  assign cfg_ok  = bus.cfg_done & bus.pll_lock;

  // A line ending in the vsync-rise cycle still belongs to the frame that is closing.
  assign line_len_bad = de_fall && (run_cnt_q != H_LEN);
  assign lines_total  = (de_fall && line_cnt_q != 11'h7FF) ? line_cnt_q + 11'd1 : line_cnt_q;
  assign frame_good   = !frame_bad_q && !line_len_bad && (lines_total == V_CNT) && !de_q;
  assign frame_ok     = vs_rise && frame_good;
  assign tmo_hit      = (timeout_cnt_q == TMO_MAX) && (state_q == TRACK || state_q == LOCKED);
  assign frame_end    = vs_rise || tmo_hit;
  assign good_inc     = good_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= WAIT_CFG;
      vs_q            <= 1'b0;
      vs_qq           <= 1'b0;
      de_q            <= 1'b0;
      de_qq           <= 1'b0;
      run_cnt_q       <= '0;
      last_len_q      <= '0;
      line_cnt_q      <= '0;
      frame_bad_q     <= 1'b0;
      timeout_cnt_q   <= '0;
      good_cnt_q      <= '0;
      tmds_rst_n_q    <= 1'b0;
      locked_q        <= 1'b0;
      meas_de_len_q   <= '0;
      meas_lines_q    <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      vs_q            <= bus.vsync;
      vs_qq           <= vs_q;
      de_q            <= bus.de;
      de_qq           <= de_q;
      run_cnt_q       <= run_cnt_d;
      last_len_q      <= last_len_d;
      line_cnt_q      <= line_cnt_d;
      frame_bad_q     <= frame_bad_d;
      timeout_cnt_q   <= timeout_cnt_d;
      good_cnt_q      <= good_cnt_d;
      tmds_rst_n_q    <= tmds_rst_n_d;
      locked_q        <= locked_d;
      meas_de_len_q   <= meas_de_len_d;
      meas_lines_q    <= meas_lines_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    run_cnt_d       = run_cnt_q;
    last_len_d      = last_len_q;
    line_cnt_d      = line_cnt_q;
    frame_bad_d     = frame_bad_q;
    timeout_cnt_d   = timeout_cnt_q;
    good_cnt_d      = good_cnt_q;
    meas_de_len_d   = meas_de_len_q;
    meas_lines_d    = meas_lines_q;
    lock_loss_cnt_d = lock_loss_cnt_q;

    if (state_q != WAIT_CFG && !cfg_ok) begin
      // Losing config or PLL overrides any frame event in the same cycle.
      state_d       = WAIT_CFG;
      good_cnt_d    = '0;
      frame_bad_d   = 1'b0;
      line_cnt_d    = '0;
      run_cnt_d     = '0;
      timeout_cnt_d = '0;
    end else if (state_q == WAIT_CFG) begin
      if (cfg_ok) begin
        state_d = SEARCH;
      end
    end else begin
      if (de_q && run_cnt_q != 12'hFFF) begin
        run_cnt_d = run_cnt_q + 12'd1;
      end
      if (de_fall) begin
        last_len_d = run_cnt_q;
        line_cnt_d = lines_total;
        run_cnt_d  = '0;
        if (line_len_bad) begin
          frame_bad_d = 1'b1;
        end
      end
      if (timeout_cnt_q != TMO_MAX) begin
        timeout_cnt_d = timeout_cnt_q + 1'b1;
      end

      if (vs_rise) begin
        meas_lines_d  = lines_total;
        meas_de_len_d = de_fall ? run_cnt_q : last_len_q;
        frame_bad_d   = 1'b0;
        line_cnt_d    = '0;
        timeout_cnt_d = '0;
      end else if (tmo_hit) begin
        frame_bad_d   = 1'b0;
        line_cnt_d    = '0;
        timeout_cnt_d = '0;
      end

      case (state_q)
        SEARCH: begin
          if (vs_rise) begin
            state_d    = TRACK;
            good_cnt_d = '0;
          end
        end
        TRACK: begin
          if (frame_end) begin
            if (frame_ok) begin
              good_cnt_d = good_inc;
              if (good_inc == STABLE) begin
                state_d = LOCKED;
              end
            end else begin
              good_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (frame_end && !frame_ok) begin
            state_d = SEARCH;
          end
        end
        default: ;
      endcase
    end

    if (state_q == LOCKED && state_d != LOCKED && lock_loss_cnt_q != 8'hFF) begin
      lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
    end

    tmds_rst_n_d = (state_d == LOCKED);
    locked_d     = (state_d == LOCKED);
  end

  assign bus.state         = state_q;
  assign bus.tmds_rst_n    = tmds_rst_n_q;
  assign bus.locked        = locked_q;
  assign bus.meas_de_len   = meas_de_len_q;
  assign bus.meas_lines    = meas_lines_q;
  assign bus.lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_stream_lock_ctrl.sv
// Directed bench for stream_lock_ctrl: frame-end expectations queued per vsync and checked one edge after the rise.
// A second instance with a one-line, one-frame lock criterion exercises lock-loss counter saturation.
module tb_stream_lock_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic sat_rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stream_lock_ctrl_if bus ();
  stream_lock_ctrl_if sbus ();

  stream_lock_ctrl #(
    .H_DE_CYCLES(16), .V_LINES(4), .STABLE_FRAMES(3), .FRAME_TIMEOUT(500)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  stream_lock_ctrl #(
    .H_DE_CYCLES(2), .V_LINES(1), .STABLE_FRAMES(1), .FRAME_TIMEOUT(500)
  ) u_sat (
    .clk(clk), .rst_n(sat_rst_n), .bus(sbus.slave)
  );

  typedef struct {
    logic [1:0]  pre_st;
    logic [1:0]  st;
    logic        lk;
    logic [7:0]  ll;
    bit          chk_meas;
    logic [10:0] ml;
    logic [11:0] md;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_vs(input logic [1:0] pre_st, input logic [1:0] st, input logic [7:0] ll,
                           input bit chk_meas, input logic [10:0] ml, input logic [11:0] md);
    exp_t e;
    e.pre_st = pre_st; e.st = st; e.lk = (st == 2'd3); e.ll = ll;
    e.chk_meas = chk_meas; e.ml = ml; e.md = md;
    sb.push_back(e);
  endtask

  // Entered and left at a negedge. Vsync is first sampled at P1; the result must appear at P2.
  task automatic vs_edge();
    exp_t e;
    bus.vsync = 1'b1;
    @(posedge clk); #1;
    if (sb.size() == 0) $fatal(1, "FAIL scoreboard underflow at vsync");
    e = sb.pop_front();
    chk("pre_state", bus.state, e.pre_st);
    chk("pre_locked", bus.locked, (e.pre_st == 2'd3));
    @(posedge clk); #1;
    chk("vs_state", bus.state, e.st);
    chk("vs_locked", bus.locked, e.lk);
    chk("vs_tmds_rst_n", bus.tmds_rst_n, e.lk);
    chk("vs_lock_loss_cnt", bus.lock_loss_cnt, e.ll);
    if (e.chk_meas) begin
      chk("vs_meas_lines", bus.meas_lines, e.ml);
      chk("vs_meas_de_len", bus.meas_de_len, e.md);
    end
    @(negedge clk);
    bus.vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_line(input int len);
    bus.de = 1'b1;
    repeat (len) @(negedge clk);
    bus.de = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input int nl, input int last);
    for (int i = 0; i < nl; i++) drive_line((i == nl - 1) ? last : 16);
  endtask

  // From SEARCH: first vsync enters TRACK, three good frames then lock.
  task automatic relock(input logic [7:0] ll);
    expect_vs(2'd1, 2'd2, ll, 1'b0, '0, '0);
    vs_edge();
    for (int k = 1; k <= 3; k++) begin
      frame(4, 16);
      expect_vs(2'd2, (k == 3) ? 2'd3 : 2'd2, ll, 1'b1, 11'd4, 12'd16);
      vs_edge();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, bus.state, 0);
    chk({tag, "_tmds_rst_n"}, bus.tmds_rst_n, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_meas_lines"}, bus.meas_lines, 0);
    chk({tag, "_meas_de_len"}, bus.meas_de_len, 0);
    chk({tag, "_lock_loss_cnt"}, bus.lock_loss_cnt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "FAIL watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; sat_rst_n = 1'b0;
    bus.cfg_done = 1'b1; bus.pll_lock = 1'b0; bus.vsync = 1'b0; bus.de = 1'b0;
    sbus.cfg_done = 1'b1; sbus.pll_lock = 1'b0; sbus.vsync = 1'b0; sbus.de = 1'b0;

    // Reset state, then idle with PLL unlocked.
    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk_all_zero("no_pll");

    // Bring-up: SEARCH, TRACK at first vsync, lock one edge after the 4th vsync rise.
    @(negedge clk) bus.pll_lock = 1'b1;
    @(posedge clk); #1;
    chk("search_entry", bus.state, 1);
    @(negedge clk);
    relock(8'd0);
    frame(4, 16);
    expect_vs(2'd3, 2'd3, 8'd0, 1'b1, 11'd4, 12'd16);
    vs_edge();

    // Short last line drops lock.
    frame(4, 15);
    expect_vs(2'd3, 2'd1, 8'd1, 1'b1, 11'd4, 12'd15);
    vs_edge();

    // Re-lock, then a five-line frame drops lock.
    relock(8'd1);
    frame(5, 16);
    expect_vs(2'd3, 2'd1, 8'd2, 1'b1, 11'd5, 12'd16);
    vs_edge();

    // Re-lock, then starve vsync until the frame timeout fires.
    relock(8'd2);
    n = 0;
    for (int i = 1; i <= 700; i++) begin
      @(posedge clk); #1;
      n = i;
      if (bus.state != 2'd3) break;
    end
    chk("timeout_window", ((n + 2) >= 499 && (n + 2) <= 503), 1);
    chk("timeout_state", bus.state, 1);
    chk("timeout_locked", bus.locked, 0);
    chk("timeout_tmds_rst_n", bus.tmds_rst_n, 0);
    chk("timeout_lock_loss_cnt", bus.lock_loss_cnt, 3);
    @(negedge clk);

    // PLL glitch in TRACK with two good frames banked.
    expect_vs(2'd1, 2'd2, 8'd3, 1'b0, '0, '0);
    vs_edge();
    for (int k = 0; k < 2; k++) begin
      frame(4, 16);
      expect_vs(2'd2, 2'd2, 8'd3, 1'b1, 11'd4, 12'd16);
      vs_edge();
    end
    bus.pll_lock = 1'b0;
    @(posedge clk); #1;
    chk("pll_drop_state", bus.state, 0);
    chk("pll_drop_lock_loss_cnt", bus.lock_loss_cnt, 3);
    @(negedge clk) bus.pll_lock = 1'b1;
    @(posedge clk); #1;
    chk("pll_back_state", bus.state, 1);
    @(negedge clk);
    relock(8'd3);

    // Reset while LOCKED.
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("mid_lock_reset");
    @(negedge clk) rst_n = 1'b1;

    // Saturation of the lock-loss counter on the fast-locking instance.
    sat_rst_n = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 260; i++) begin
      sbus.pll_lock = 1'b1;
      @(negedge clk);
      sbus.vsync = 1'b1; repeat (2) @(negedge clk);
      sbus.vsync = 1'b0; repeat (2) @(negedge clk);
      sbus.de = 1'b1;    repeat (2) @(negedge clk);
      sbus.de = 1'b0;    repeat (3) @(negedge clk);
      sbus.vsync = 1'b1; repeat (2) @(negedge clk);
      sbus.vsync = 1'b0; repeat (2) @(negedge clk);
      if (i == 1) chk("sat_locked", sbus.locked, 1);
      sbus.pll_lock = 1'b0;
      @(negedge clk);
      if (i == 1 || i == 100 || i == 254 || i == 255)
        chk($sformatf("sat_loss_%0d", i), sbus.lock_loss_cnt, i);
    end
    chk("sat_loss_final", sbus.lock_loss_cnt, 255);
    chk("sat_state_final", sbus.state, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
